// File: rtl/bsg_axi_pkg.sv
// bsg_axi_pkg: AXI response/burst codes and the responder state encoding
package bsg_axi_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;
    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} resp_state_e;
endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port synchronous SRAM with byte write mask
//   v_i/w_i: access enable / write select; read data appears on data_o next cycle
//   addr_i, data_i, write_mask_i (one bit per byte), data_o
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int width_p = 32,
    parameter int els_p   = 64,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p/8-1:0]     write_mask_i,
    output logic [width_p-1:0]       data_o
);
    logic [width_p-1:0] mem_q [els_p];
    always_ff @(posedge clk_i) begin
        if (v_i & w_i)
            for (int i = 0; i < width_p/8; i++)
                if (write_mask_i[i]) mem_q[addr_i][i*8+:8] <= data_i[i*8+:8];
        if (v_i & ~w_i) data_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry FIFO; entries reset to zero so data_o is 0 after reset
//   clk_i/reset_n_i: clock, async active-low reset
//   v_i/data_i/ready_o: enqueue side (ready_o = not full)
//   v_o/data_o/yumi_i: dequeue side (yumi_i only while v_o)
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_q [2];
    logic               rd_q, wr_q;
    logic [1:0]         cnt_q;
    logic               enq;
    assign enq     = v_i & ready_o;
    assign v_o     = cnt_q != 2'd0;
    assign ready_o = cnt_q != 2'd2;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (enq) mem_q[wr_q] <= data_i;
            wr_q  <= wr_q ^ enq;
            rd_q  <= rd_q ^ yumi_i;
            cnt_q <= cnt_q + {1'b0, enq} - {1'b0, yumi_i};
        end
    end
endmodule

// File: rtl/bsg_axi_mem_responder.sv
// bsg_axi_mem_responder: AXI4 slave serving one INCR burst at a time from a local SRAM
//   clk_i, reset_n_i (async active-low)
//   AW/W/B: write address, data (wlast ignored, len+1 beats taken), response
//   AR/R:   read address, data through a two-entry R buffer
//   size/burst/cache/prot/lock are ignored; indices wrap modulo mem_els_p
//   BSG_AXI_MEM_RESPONDER_RANGE_CHECK_EN: bursts running past the top return SLVERR
module bsg_axi_mem_responder
    import bsg_axi_pkg::*;
#(
    parameter int axi_id_width_p   = 4,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 32,
    parameter int mem_els_p        = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [7:0]                    axi_awlen_i,
    input  logic [2:0]                    axi_awsize_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic [3:0]                    axi_awcache_i,
    input  logic [2:0]                    axi_awprot_i,
    input  logic                          axi_awlock_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,
    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,
    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,
    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [7:0]                    axi_arlen_i,
    input  logic [2:0]                    axi_arsize_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic [3:0]                    axi_arcache_i,
    input  logic [2:0]                    axi_arprot_i,
    input  logic                          axi_arlock_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,
    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);
    localparam int lg_els_lp     = $clog2(mem_els_p);
    localparam int byte_shift_lp = $clog2(axi_data_width_p/8);
    localparam int fifo_w_lp     = axi_id_width_p + axi_data_width_p + 3;

    resp_state_e                 state_q;
    logic                        last_w_q, err_q, infl_q, infl_last_q;
    logic [axi_id_width_p-1:0]   id_q;
    logic [7:0]                  len_q;
    logic [lg_els_lp-1:0]        idx_q, aw_idx, ar_idx, mem_addr;
    logic [8:0]                  cnt_q;
    logic                        idle, grant_w, grant_r, w_fire, w_done;
    logic                        rd_issue, rd_last_beat, rd_room, aw_err, ar_err;
    logic                        f_v, f_ready, f_deq;
    logic [1:0]                  rd_pend;
    logic [axi_data_width_p-1:0] mem_data;
    logic [fifo_w_lp-1:0]        f_data;
    logic                        unused;

    assign unused = ^{axi_awsize_i, axi_awburst_i, axi_awcache_i, axi_awprot_i, axi_awlock_i,
                      axi_arsize_i, axi_arburst_i, axi_arcache_i, axi_arprot_i, axi_arlock_i,
                      axi_wlast_i, axi_awaddr_i, axi_araddr_i};

    // Contested requests go to whichever channel was not granted last
    assign idle          = state_q == IDLE;
    assign grant_w       = idle & axi_awvalid_i & (~axi_arvalid_i | ~last_w_q);
    assign grant_r       = idle & axi_arvalid_i & (~axi_awvalid_i | last_w_q);
    assign axi_awready_o = grant_w;
    assign axi_arready_o = grant_r;
    assign aw_idx        = lg_els_lp'(axi_awaddr_i >> byte_shift_lp);
    assign ar_idx        = lg_els_lp'(axi_araddr_i >> byte_shift_lp);

`ifdef BSG_AXI_MEM_RESPONDER_RANGE_CHECK_EN
    logic [axi_addr_width_p:0] aw_end, ar_end;
    assign aw_end = {1'b0, axi_awaddr_i >> byte_shift_lp} + (axi_addr_width_p+1)'(axi_awlen_i);
    assign ar_end = {1'b0, axi_araddr_i >> byte_shift_lp} + (axi_addr_width_p+1)'(axi_arlen_i);
    assign aw_err = aw_end >= (axi_addr_width_p+1)'(mem_els_p);
    assign ar_err = ar_end >= (axi_addr_width_p+1)'(mem_els_p);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign axi_wready_o = state_q == WR_DATA;
    assign w_fire       = axi_wready_o & axi_wvalid_i;
    assign w_done       = w_fire & (cnt_q == {1'b0, len_q});
    assign axi_bvalid_o = state_q == WR_RESP;
    assign axi_bid_o    = id_q;
    assign axi_bresp_o  = err_q ? SLVERR : OKAY;

    // Pending count nets out this cycle's dequeue so a drained beat can be
    // replaced immediately, giving one beat per cycle without overflowing the buffer
    assign f_deq        = f_v & axi_rready_i;
    assign rd_pend      = {1'b0, f_v} + {1'b0, ~f_ready} + {1'b0, infl_q} - {1'b0, f_deq};
    assign rd_room      = rd_pend < 2'd2;
    // Beat 0 is issued in the AR handshake cycle so it surfaces two cycles later
    assign rd_issue     = grant_r | ((state_q == RD_DATA) & rd_room & (cnt_q <= {1'b0, len_q}));
    assign rd_last_beat = grant_r ? (axi_arlen_i == 8'd0) : (cnt_q == {1'b0, len_q});
    assign mem_addr     = grant_r ? ar_idx : idx_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            last_w_q    <= 1'b0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            id_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            infl_q      <= rd_issue;
            infl_last_q <= rd_last_beat;
            case (state_q)
                IDLE: begin
                    if (grant_w) begin
                        state_q  <= WR_DATA;
                        last_w_q <= 1'b1;
                        id_q     <= axi_awid_i;
                        len_q    <= axi_awlen_i;
                        idx_q    <= aw_idx;
                        cnt_q    <= 9'd0;
                        err_q    <= aw_err;
                    end else if (grant_r) begin
                        state_q  <= RD_DATA;
                        last_w_q <= 1'b0;
                        id_q     <= axi_arid_i;
                        len_q    <= axi_arlen_i;
                        idx_q    <= ar_idx + 1'b1;
                        cnt_q    <= 9'd1;
                        err_q    <= ar_err;
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= cnt_q + 9'd1;
                    end
                    if (w_done) state_q <= WR_RESP;
                end
                WR_RESP: if (axi_bready_i) state_q <= IDLE;
                RD_DATA: begin
                    if (rd_issue) begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= cnt_q + 9'd1;
                    end
                    if (f_deq & axi_rlast_o) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .width_p(axi_data_width_p),
        .els_p  (mem_els_p)
    ) mem (
        .clk_i       (clk_i),
        .v_i         (rd_issue | (w_fire & ~err_q)),
        .w_i         (w_fire),
        .addr_i      (mem_addr),
        .data_i      (axi_wdata_i),
        .write_mask_i(axi_wstrb_i),
        .data_o      (mem_data)
    );

    bsg_two_fifo #(.width_p(fifo_w_lp)) r_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (infl_q),
        .data_i   ({id_q, err_q ? '0 : mem_data, err_q ? SLVERR : OKAY, infl_last_q}),
        .ready_o  (f_ready),
        .v_o      (f_v),
        .data_o   (f_data),
        .yumi_i   (f_deq)
    );

    assign {axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o} = f_data;
    assign axi_rvalid_o = f_v;
endmodule

// File: tb/tb_bsg_axi_mem_responder.sv
// tb_bsg_axi_mem_responder: directed checks of the AXI memory responder
module tb_bsg_axi_mem_responder;
    logic        clk_i = 1'b0, reset_n_i = 1'b0;
    logic [3:0]  axi_awid_i = '0, axi_arid_i = '0, axi_bid_o, axi_rid_o;
    logic [31:0] axi_awaddr_i = '0, axi_araddr_i = '0, axi_wdata_i = '0, axi_rdata_o;
    logic [7:0]  axi_awlen_i = '0, axi_arlen_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_awvalid_i = 0, axi_arvalid_i = 0, axi_wvalid_i = 0, axi_wlast_i = 0;
    logic        axi_bready_i = 0, axi_rready_i = 0;
    logic        axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;

    always #5 clk_i = ~clk_i;

    bsg_axi_mem_responder #(
        .axi_id_width_p(4), .axi_addr_width_p(32), .axi_data_width_p(32), .mem_els_p(64)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(3'd2), .axi_awburst_i(2'b01), .axi_awcache_i(4'd0), .axi_awprot_i(3'd0),
        .axi_awlock_i(1'b0), .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(3'd2), .axi_arburst_i(2'b01), .axi_arcache_i(4'd0), .axi_arprot_i(3'd0),
        .axi_arlock_i(1'b0), .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int t_aw, t_ar, t_wrdy, t_wl, t_bv, t_rv, r_n;
    logic [31:0] r_data [16];
    logic        r_last [16];
    logic [1:0]  r_resp [16];
    logic [3:0]  r_id [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic aw_set(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len; axi_awvalid_i = 1;
    endtask

    task automatic ar_set(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len; axi_arvalid_i = 1;
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk_i);
        while (!axi_awready_o && n < 50) begin n++; @(negedge clk_i); end
        if (!axi_awready_o) check("aw_timeout", axi_awready_o, 1);
        t_aw = cyc;
        @(posedge clk_i); #1 axi_awvalid_i = 0;
    endtask

    task automatic wait_ar();
        int n = 0;
        @(negedge clk_i);
        while (!axi_arready_o && n < 50) begin n++; @(negedge clk_i); end
        if (!axi_arready_o) check("ar_timeout", axi_arready_o, 1);
        t_ar = cyc;
        @(posedge clk_i); #1 axi_arvalid_i = 0;
    endtask

    task automatic wait_any(output bit got_w);
        int n = 0;
        @(negedge clk_i);
        while (!(axi_awready_o | axi_arready_o) && n < 50) begin n++; @(negedge clk_i); end
        if (!(axi_awready_o | axi_arready_o)) check("grant_timeout", axi_awready_o | axi_arready_o, 1);
        check("one_grant", axi_awready_o & axi_arready_o, 0);
        got_w = axi_awready_o;
        t_aw = cyc; t_ar = cyc;
        @(posedge clk_i); #1
        if (got_w) axi_awvalid_i = 0; else axi_arvalid_i = 0;
    endtask

    task automatic w_burst(input logic [7:0] len, input logic [31:0] d0, input logic [31:0] inc,
                           input logic [3:0] strb);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            axi_wdata_i = d0 + i * inc; axi_wstrb_i = strb;
            axi_wlast_i = (i == int'(len)); axi_wvalid_i = 1;
            @(negedge clk_i);
            while (!axi_wready_o && n < 50) begin n++; @(negedge clk_i); end
            if (!axi_wready_o) check("w_timeout", axi_wready_o, 1);
            if (i == 0) t_wrdy = cyc;
            t_wl = cyc;
            @(posedge clk_i); #1;
        end
        axi_wvalid_i = 0; axi_wlast_i = 0;
    endtask

    task automatic b_get();
        int n = 0;
        axi_bready_i = 1;
        @(negedge clk_i);
        while (!axi_bvalid_o && n < 50) begin n++; @(negedge clk_i); end
        if (!axi_bvalid_o) check("b_timeout", axi_bvalid_o, 1);
        t_bv = cyc; b_resp = axi_bresp_o; b_id = axi_bid_o;
        @(posedge clk_i); #1 axi_bready_i = 0;
    endtask

    task automatic r_get(input logic [7:0] len, input bit toggle);
        int n = 0;
        bit first = 1;
        r_n = 0;
        axi_rready_i = 1;
        while (r_n <= int'(len) && n < 200) begin
            @(negedge clk_i);
            n++;
            if (axi_rvalid_o && first) begin t_rv = cyc; first = 0; end
            if (axi_rvalid_o && axi_rready_i) begin
                r_data[r_n] = axi_rdata_o; r_last[r_n] = axi_rlast_o;
                r_resp[r_n] = axi_rresp_o; r_id[r_n] = axi_rid_o;
                r_n++;
            end
            @(posedge clk_i); #1
            if (toggle) axi_rready_i = ~axi_rready_i;
        end
        axi_rready_i = 0;
        if (r_n <= int'(len)) check("r_timeout", r_n, int'(len) + 1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] d0, input logic [31:0] inc, input logic [3:0] strb);
        aw_set(id, addr, len); wait_aw(); w_burst(len, d0, inc, strb); b_get();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit toggle);
        ar_set(id, addr, len); wait_ar(); r_get(len, toggle);
    endtask

    initial begin
        bit got_w;
        int wi, ri, n;
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1;
        @(negedge clk_i);
        check("rst_awready", axi_awready_o, 0);
        check("rst_wready", axi_wready_o, 0);
        check("rst_bvalid", axi_bvalid_o, 0);
        check("rst_rvalid", axi_rvalid_o, 0);
        check("rst_bid_bresp", {axi_bid_o, axi_bresp_o}, 0);
        check("rst_r_fields", {axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o}, 0);
        @(posedge clk_i); #1;

        // single beat write then read, with latency checks
        do_write(4'h3, 32'h40, 8'd0, 32'hDEADBEEF, 0, 4'hF);
        check("t1_bresp", b_resp, 2'b00);
        check("t1_bid", b_id, 4'h3);
        check("t1_wready_lat", t_wrdy - t_aw, 1);
        check("t1_bvalid_lat", t_bv - t_wl, 1);
        do_read(4'h5, 32'h40, 8'd0, 0);
        check("t1_rdata", r_data[0], 32'hDEADBEEF);
        check("t1_rlast_rid_rresp", {r_last[0], r_id[0], r_resp[0]}, {1'b1, 4'h5, 2'b00});
        check("t1_rvalid_lat", t_rv - t_ar, 2);

        // 16 beat burst, read back with rready toggling
        do_write(4'h1, 32'h80, 8'd15, 32'h1000, 1, 4'hF);
        check("t2_bresp", b_resp, 2'b00);
        do_read(4'h2, 32'h80, 8'd15, 1);
        check("t2_beats", r_n, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t2_beat%0d", i), {r_last[i], r_data[i]}, {i == 15, 32'h1000 + i});

        // partial strobe
        do_write(4'h4, 32'h20, 8'd0, 32'h11223344, 0, 4'hF);
        do_write(4'h4, 32'h20, 8'd0, 32'hAABBCCDD, 0, 4'b0101);
        do_read(4'h4, 32'h20, 8'd0, 0);
        check("t3_strobe", r_data[0], 32'h11BB33DD);

        // burst starting at the top index
        do_write(4'h7, 32'h0, 8'd0, 32'h55555555, 0, 4'hF);
        do_write(4'h7, 32'hFC, 8'd1, 32'hCAFE0000, 1, 4'hF);
        do_read(4'h8, 32'h0, 8'd0, 0);
`ifdef BSG_AXI_MEM_RESPONDER_RANGE_CHECK_EN
        check("t4_bresp", b_resp, 2'b10);
        check("t4_idx0", r_data[0], 32'h55555555);
        do_read(4'h8, 32'hFC, 8'd1, 0);
        check("t4_rd0", {r_data[0], r_resp[0], r_last[0]}, {32'h0, 2'b10, 1'b0});
        check("t4_rd1", {r_data[1], r_resp[1], r_last[1]}, {32'h0, 2'b10, 1'b1});
`else
        check("t4_bresp", b_resp, 2'b00);
        check("t4_idx0", r_data[0], 32'hCAFE0001);
        do_read(4'h8, 32'hFC, 8'd1, 0);
        check("t4_rd0", {r_data[0], r_resp[0], r_last[0]}, {32'hCAFE0000, 2'b00, 1'b0});
        check("t4_rd1", {r_data[1], r_resp[1], r_last[1]}, {32'hCAFE0001, 2'b00, 1'b1});
`endif

        // reset during beat 3 of an 8 beat read
        ar_set(4'h6, 32'h80, 8'd7); wait_ar();
        axi_rready_i = 1; r_n = 0; n = 0;
        while (r_n < 3 && n < 50) begin
            @(negedge clk_i); n++;
            if (axi_rvalid_o) r_n++;
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("t5_beat3_valid", axi_rvalid_o, 1);
        check("t5_beat3_data", axi_rdata_o, 32'h1003);
        reset_n_i = 0;
        @(negedge clk_i);
        check("t5_rst_rvalid", axi_rvalid_o, 0);
        check("t5_rst_bvalid_wready", {axi_bvalid_o, axi_wready_o}, 0);
        @(posedge clk_i); #1 reset_n_i = 1; axi_rready_i = 0;
        do_read(4'h9, 32'h40, 8'd0, 0);
        check("t5_fresh_ar", {r_n[7:0], r_id[0], r_last[0], r_resp[0]}, {8'd1, 4'h9, 1'b1, 2'b00});

        // contested arbitration: last grant was read, so write goes first
        wi = 0; ri = 0;
        for (int k = 0; k < 6; k++) begin
            if (wi < 3 && !axi_awvalid_i) aw_set(4'(1 + wi), 32'hC0, 8'd0);
            if (ri < 3 && !axi_arvalid_i) ar_set(4'(10 + ri), 32'hC0, 8'd0);
            wait_any(got_w);
            check($sformatf("arb_grant%0d", k), got_w, (k % 2) == 0);
            if (got_w) begin
                w_burst(8'd0, 32'hA0 + wi, 0, 4'hF); b_get();
                check($sformatf("arb_bid%0d", wi), b_id, 4'(1 + wi));
                wi++;
            end else begin
                r_get(8'd0, 0);
                check($sformatf("arb_rid%0d", ri), {r_id[0], r_data[0]}, {4'(10 + ri), 32'hA0 + ri});
                ri++;
            end
        end
        axi_awvalid_i = 0; axi_arvalid_i = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bsg_axi_mem_responder.md
# bsg_axi_mem_responder

Synthesizable AXI4 slave that terminates the burst traffic issued by the manycore cache-to-AXI path, serving reads and writes from a local single-port SRAM. It is the responder end of the AXI interface driven by the vcache DMA bridge. It replaces the DRAM/shell model in small-configuration emulation and FPGA bring-up builds, with no external memory controller.

## Interface
- axi_id_width_p, "inv": AXI ID width; IDs are echoed unchanged.
- axi_addr_width_p, "inv": AXI byte-address width.
- axi_data_width_p, "inv": beat width; power of two, ≥ 32.
- mem_els_p, "inv": SRAM depth in beats; power of two.
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- axi_aw{id,addr,len,size,burst,cache,prot,lock,valid}_i / axi_awready_o: write address channel, standard AXI4 widths.
- axi_w{data,strb,last,valid}_i / axi_wready_o: write data channel; strb is axi_data_width_p/8.
- axi_b{id,resp,valid}_o / axi_bready_i: write response channel.
- axi_ar{id,addr,len,size,burst,cache,prot,lock,valid}_i / axi_arready_o: read address channel.
- axi_r{id,data,resp,last,valid}_o / axi_rready_i: read data channel.

## Operation
- The SRAM has one port, so exactly one burst is in service at a time.
- FSM states:
  - IDLE
  - WR_DATA
  - WR_RESP
  - RD_DATA
- IDLE arbitration:
  - awready_o = grant_w and arready_o = grant_r; at most one is high in any cycle.
  - If only one of awvalid/arvalid is high, that channel is granted.
  - If both are high, the channel not granted last time wins; the last-grant flop resets to "read", so the first contested grant goes to write.
- AW handshake:
  - Latch id, len, and word index = awaddr >> log2(axi_data_width_p/8).
  - Go to WR_DATA.
- WR_DATA:
  - wready_o=1.
  - Each accepted beat writes the SRAM with the byte mask from wstrb, then increments the index.
  - The burst ends when the beat count reaches len+1; wlast does not terminate the burst and is ignored.
  - After the final beat, go to WR_RESP.
- WR_RESP:
  - bvalid_o=1 with the latched bid.
  - On bready, go to IDLE.
- AR handshake:
  - Latch id, len and index.
  - Go to RD_DATA.
- RD_DATA:
  - A read is issued when (R-buffer occupancy + in-flight reads) < 2 and issued count ≤ len.
  - SRAM data enters the R buffer one cycle after issue.
  - rlast is set on beat number len.
  - The FSM returns to IDLE on the cycle the last beat handshakes.
- size and burst are ignored: every burst is treated as INCR at full beat width. cache, prot and lock are ignored.
- Index arithmetic is modulo mem_els_p, so an index past the top wraps to 0.

## Timing
- Reset values:
  - All *valid_o and *ready_o are 0.
  - bid_o, rid_o, bresp_o, rresp_o and rdata_o are 0.
  - rlast_o is 0.
  - FSM is in IDLE.
- awready_o/arready_o depend combinationally on the valid inputs; all other outputs are registered or derived from state.
- Write path:
  - AW handshake at cycle t gives wready_o at t+1.
  - A final W beat at cycle u gives bvalid_o at u+1.
  - The earliest next AW/AR acceptance is the cycle after the B handshake.
- Read path:
  - AR handshake at cycle t gives the first rvalid_o at t+2.
  - With rready held high, beats follow one per cycle.
  - When rready drops, rvalid and rdata are held stable with no beat lost or duplicated.
- A reset assertion mid-burst aborts the burst immediately. No B or R response is ever produced for it, and SRAM contents are unspecified.

## Configuration
- BSG_AXI_MEM_RESPONDER_RANGE_CHECK_EN: defined adds address range checking; undefined keeps wrap-around with no errors.
- With the macro defined:
  - A burst whose start index + len ≥ mem_els_p is flagged at the AW/AR handshake.
  - A flagged write drops all of its beats and returns bresp=SLVERR (2'b10).
  - A flagged read returns len+1 beats of data 0, each with rresp=SLVERR.
- Without the macro:
  - No checking is done; the index wraps.
  - bresp and rresp are always OKAY (2'b00).

## Structure
- Package bsg_axi_pkg holds:
  - the resp codes OKAY/SLVERR;
  - the burst code INCR;
  - the responder state enum.
- The SRAM is bsg_mem_1rw_sync_mask_write_byte.
- The R output buffer is a sub-module, bsg_two_fifo (width rid+rdata+rresp+rlast).

## Test plan
- Single-beat write then read: write awaddr=0x40, len=0, wdata=0xDEADBEEF, full strb, then read 0x40 → bresp=OKAY, then rdata=0xDEADBEEF with rlast=1.
- 16-beat burst with stalls: write len=15 with incrementing data, then read back with rready toggled every other cycle → 16 beats in order, rlast only on beat 15, no duplicates.
- Partial strobe: preload 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 → read returns 0x11BB33DD.
- Arbitration: awvalid and arvalid asserted together for three consecutive transactions each → grants go write, read, write; IDs are echoed correctly on B and R.
- Wrap / range check: write starting at index mem_els_p−1 with len=1:
  - Without the macro: index 0 is written and bresp=OKAY.
  - With the macro: bresp=SLVERR, memory unchanged, and a read of the same burst returns 0s with SLVERR.
- Reset mid-read: assert reset_n_i=0 during beat 3 of a len=7 read → all valids are 0 next cycle, and the FSM accepts a fresh AR after release.
